// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: access FSM states, requester IDs
// and default bus widths.
`timescale 1ns/1ps
package mem_port_arbiter_pkg;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } arb_state_t;

   typedef enum logic {
      REQ_CPU = 1'b0,
      REQ_VID = 1'b1
   } req_id_t;

   // The winner may only change in states where no access is being issued.
   function automatic logic is_arb_point(input arb_state_t s);
      return (s == ST_IDLE) || (s == ST_RESP);
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the CPU and video requesters.
// Build option MEM_ARB_RR_EN: round-robin tie-break instead of fixed CPU priority.
`timescale 1ns/1ps
module mem_arb_pick
   import mem_port_arbiter_pkg::*;
(
   input  logic    cpu_req,
   input  logic    vid_req,
`ifdef MEM_ARB_RR_EN
   input  req_id_t last_gnt,
`else
   input  logic    starve,
`endif
   output req_id_t win
);

   always_comb begin
      win = REQ_CPU;
      if (cpu_req && vid_req) begin
`ifdef MEM_ARB_RR_EN
         win = (last_gnt == REQ_CPU) ? REQ_VID : REQ_CPU;
`else
         // A video request that has waited MAX_WAIT cycles beats the CPU once.
         win = starve ? REQ_VID : REQ_CPU;
`endif
      end else if (vid_req) begin
         win = REQ_VID;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous block RAM between CPU and video read port with a
// 3-state IDLE/ISSUE/RESP access FSM. Build option MEM_ARB_RR_EN selects round-robin.
`timescale 1ns/1ps
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int MAX_WAIT = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              CpuReq,
   input  logic              CpuWe,
   input  logic [ADDR_W-1:0] CpuAddr,
   input  logic [DATA_W-1:0] CpuWData,
   output logic              CpuGnt,
   output logic              CpuValid,
   output logic [DATA_W-1:0] CpuRData,
   input  logic              VidReq,
   input  logic [ADDR_W-1:0] VidAddr,
   output logic              VidGnt,
   output logic              VidValid,
   output logic [DATA_W-1:0] VidRData,
   output logic [ADDR_W-1:0] RamAddr,
   output logic [DATA_W-1:0] RamWData,
   output logic              RamWe,
   input  logic [DATA_W-1:0] RamRData,
   output arb_state_t        DbgState
);

   // Handshake: a requester holds Req until it sees its one-cycle Gnt; the
   // matching Valid pulse follows exactly one cycle after Gnt. Req sampled
   // high again in the Valid cycle counts as a new request.

   arb_state_t state_q, state_d;
   req_id_t    owner_q;
   req_id_t    win;
   logic       any_req;
   logic       take;

   assign any_req = CpuReq | VidReq;
   assign take    = is_arb_point(state_q) && any_req;

`ifdef MEM_ARB_RR_EN
   req_id_t last_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         last_q <= REQ_VID;
      end else if (state_q == ST_ISSUE) begin
         last_q <= owner_q;
      end
   end

   mem_arb_pick u_pick (
      .cpu_req  (CpuReq),
      .vid_req  (VidReq),
      .last_gnt (last_q),
      .win      (win)
   );
`else
   localparam int VW = $clog2(MAX_WAIT + 1);

   logic [VW-1:0] vid_wait_q;
   logic          starve;

   assign starve = (vid_wait_q == VW'(MAX_WAIT));

   always_ff @(posedge Clk) begin
      if (Reset) begin
         vid_wait_q <= '0;
      end else if (VidGnt) begin
         vid_wait_q <= '0;
      end else if (VidReq && !starve) begin
         vid_wait_q <= vid_wait_q + VW'(1);
      end
   end

   mem_arb_pick u_pick (
      .cpu_req (CpuReq),
      .vid_req (VidReq),
      .starve  (starve),
      .win     (win)
   );
`endif

   always_comb begin
      state_d = ST_IDLE;
      case (state_q)
         ST_IDLE:  state_d = any_req ? ST_ISSUE : ST_IDLE;
         ST_ISSUE: state_d = ST_RESP;
         ST_RESP:  state_d = any_req ? ST_ISSUE : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // The RAM port is loaded at the arbitration edge so it is already valid
   // throughout ISSUE; the RAM samples it at the edge that ends ISSUE.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= ST_IDLE;
         owner_q  <= REQ_CPU;
         RamAddr  <= '0;
         RamWData <= '0;
         RamWe    <= 1'b0;
      end else begin
         state_q <= state_d;
         RamWe   <= 1'b0;
         if (take) begin
            owner_q <= win;
            if (win == REQ_CPU) begin
               RamAddr  <= CpuAddr;
               RamWData <= CpuWData;
               RamWe    <= CpuWe;
            end else begin
               RamAddr  <= VidAddr;
               RamWData <= '0;
            end
         end
      end
   end

   always_comb begin
      CpuGnt   = (state_q == ST_ISSUE) && (owner_q == REQ_CPU);
      VidGnt   = (state_q == ST_ISSUE) && (owner_q == REQ_VID);
      CpuValid = (state_q == ST_RESP)  && (owner_q == REQ_CPU);
      VidValid = (state_q == ST_RESP)  && (owner_q == REQ_VID);
      CpuRData = CpuValid ? RamRData : '0;
      VidRData = VidValid ? RamRData : '0;
      DbgState = state_q;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grant order and response data are
// checked by a negedge monitor against expected queues filled by the drivers.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int AW = 16;
   localparam int DW = 16;

   // clock / reset
   logic Clk = 1'b0;
   logic Reset;
   always #5 Clk = ~Clk;

   logic          CpuReq, CpuWe, CpuGnt, CpuValid;
   logic [AW-1:0] CpuAddr;
   logic [DW-1:0] CpuWData, CpuRData;
   logic          VidReq, VidGnt, VidValid;
   logic [AW-1:0] VidAddr;
   logic [DW-1:0] VidRData;
   logic [AW-1:0] RamAddr;
   logic [DW-1:0] RamWData, RamRData;
   logic          RamWe;
   arb_state_t    DbgState;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(8)) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .CpuReq   (CpuReq),
      .CpuWe    (CpuWe),
      .CpuAddr  (CpuAddr),
      .CpuWData (CpuWData),
      .CpuGnt   (CpuGnt),
      .CpuValid (CpuValid),
      .CpuRData (CpuRData),
      .VidReq   (VidReq),
      .VidAddr  (VidAddr),
      .VidGnt   (VidGnt),
      .VidValid (VidValid),
      .VidRData (VidRData),
      .RamAddr  (RamAddr),
      .RamWData (RamWData),
      .RamWe    (RamWe),
      .RamRData (RamRData),
      .DbgState (DbgState)
   );

   // read-first synchronous RAM
   logic [DW-1:0] mem [0:65535];
   always @(posedge Clk) begin
      if (RamWe) mem[RamAddr] <= RamWData;
      RamRData <= mem[RamAddr];
   end

   // scoreboard
   int            checks = 0;
   int            errors = 0;
   logic [DW:0]   exp_q[$];   // {is_vid, rdata}
   logic          gnt_q[$];   // 0 = CPU, 1 = VID

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   always @(negedge Clk) begin
      if (CpuGnt || VidGnt) begin
         chk("one_gnt", {62'd0, CpuGnt, VidGnt} == 64'd3, 64'd0);
         if (gnt_q.size() == 0) begin
            chk("unexpected_gnt", {63'd0, VidGnt}, 64'h2);
         end else begin
            logic g;
            g = gnt_q.pop_front();
            chk("gnt_order", {63'd0, VidGnt}, {63'd0, g});
         end
      end
      if (CpuValid || VidValid) begin
         chk("one_valid", {62'd0, CpuValid, VidValid} == 64'd3, 64'd0);
         chk("gnt_valid_overlap", (CpuGnt && CpuValid) || (VidGnt && VidValid), 64'd0);
         if (exp_q.size() == 0) begin
            chk("unexpected_valid", {63'd0, VidValid}, 64'h2);
         end else begin
            logic [DW:0] e;
            e = exp_q.pop_front();
            chk("resp_src", {63'd0, VidValid}, {63'd0, e[DW]});
            chk("resp_data", VidValid ? VidRData : CpuRData, e[DW-1:0]);
            chk("idle_rdata_zero", VidValid ? CpuRData : VidRData, 64'd0);
         end
      end
   end

   // drivers: each starts in an idle cycle k, returns in idle cycle k+3
   task automatic cpu_access(input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd);
      CpuReq = 1'b1; CpuWe = we; CpuAddr = addr; CpuWData = wdata;
      gnt_q.push_back(1'b0);
      exp_q.push_back({1'b0, exp_rd});
      chk("cpu_no_early_gnt", CpuGnt, 64'd0);
      tick();
      chk("cpu_gnt_lat", CpuGnt, 64'd1);
      chk("cpu_ram_we", RamWe, we);
      chk("cpu_ram_addr", RamAddr, addr);
      chk("cpu_ram_wdata", RamWData, wdata);
      CpuReq = 1'b0;
      tick();
      chk("cpu_valid_lat", CpuValid, 64'd1);
      chk("cpu_ram_we_off", RamWe, 64'd0);
      tick();
      chk("cpu_back_idle", 64'(DbgState), 64'(ST_IDLE));
   endtask

   task automatic vid_access(input logic [AW-1:0] addr, input logic [DW-1:0] exp_rd);
      VidReq = 1'b1; VidAddr = addr;
      gnt_q.push_back(1'b1);
      exp_q.push_back({1'b1, exp_rd});
      tick();
      chk("vid_gnt_lat", VidGnt, 64'd1);
      chk("vid_ram_we", RamWe, 64'd0);
      chk("vid_ram_wdata", RamWData, 64'd0);
      chk("vid_ram_addr", RamAddr, addr);
      chk("vid_cpu_quiet_gnt", {CpuGnt, CpuValid, CpuRData}, 64'd0);
      VidReq = 1'b0;
      tick();
      chk("vid_valid_lat", VidValid, 64'd1);
      chk("vid_cpu_quiet_resp", {CpuGnt, CpuValid, CpuRData}, 64'd0);
      tick();
   endtask

   initial begin
      logic vid;
      for (int i = 0; i < 65536; i++) mem[i] = '0;
      mem[16'h0020] = 16'h5A5A;
      mem[16'h0100] = 16'h1234;
      mem[16'h0200] = 16'h1111;
      mem[16'h0300] = 16'h2222;

      // reset held 2 cycles with a pending CPU read
      Reset = 1'b1;
      CpuReq = 1'b1; CpuWe = 1'b0; CpuAddr = 16'h0020; CpuWData = '0;
      VidReq = 1'b0; VidAddr = '0;
      gnt_q.push_back(1'b0);
      exp_q.push_back({1'b0, 16'h5A5A});
      for (int c = 0; c < 2; c++) begin
         tick();
         chk("reset_outs", {CpuGnt, CpuValid, CpuRData, VidGnt, VidValid, VidRData,
                            RamWe, RamAddr, RamWData}, 64'd0);
         chk("reset_state", 64'(DbgState), 64'(ST_IDLE));
      end
      Reset = 1'b0;
      chk("rst_rel_no_gnt", CpuGnt, 64'd0);
      tick();
      chk("rst_first_gnt", CpuGnt, 64'd1);
      CpuReq = 1'b0;
      tick();
      chk("rst_first_valid", CpuValid, 64'd1);
      tick();

      // CPU write then read back
      cpu_access(1'b1, 16'h0010, 16'hBEEF, 16'h0000);
      cpu_access(1'b0, 16'h0010, 16'h0000, 16'hBEEF);

      // video alone
      vid_access(16'h0100, 16'h1234);

      // both requesting continuously for 10 grants
      CpuReq = 1'b1; CpuWe = 1'b0; CpuAddr = 16'h0200;
      VidReq = 1'b1; VidAddr = 16'h0300;
      for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_RR_EN
         vid = i[0];
`else
         vid = ((i % 5) == 4);
`endif
         gnt_q.push_back(vid);
         exp_q.push_back(vid ? {1'b1, 16'h2222} : {1'b0, 16'h1111});
      end
      repeat (19) tick();
`ifdef MEM_ARB_RR_EN
      chk("rr_last_gnt_vid", VidGnt, 64'd1);
`else
      chk("starve_gnt_vid", VidGnt, 64'd1);
`endif
      CpuReq = 1'b0; VidReq = 1'b0;
      repeat (2) tick();
      chk("contend_idle", 64'(DbgState), 64'(ST_IDLE));

      // reset during the ISSUE cycle of a CPU read
      CpuReq = 1'b1; CpuWe = 1'b0; CpuAddr = 16'h0010;
      gnt_q.push_back(1'b0);
      tick();
      chk("mid_rst_gnt", CpuGnt, 64'd1);
      Reset = 1'b1; CpuReq = 1'b0;
      tick();
      chk("mid_rst_state", 64'(DbgState), 64'(ST_IDLE));
      chk("mid_rst_no_valid", CpuValid, 64'd0);
      tick();
      chk("mid_rst_no_valid2", CpuValid, 64'd0);
      Reset = 1'b0;
      cpu_access(1'b0, 16'h0010, 16'h0000, 16'hBEEF);

      repeat (3) tick();
      chk("gnt_q_drained", gnt_q.size(), 64'd0);
      chk("exp_q_drained", exp_q.size(), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences and shares the single-port data/instruction block RAM between two requesters: the CPU (fetch, load, store) and the video/IO read port. It sits between the CPU control FSM and the memory datapath. It runs a 3-state access FSM with a req/grant/valid handshake and fixed-latency responses. Arbitration is fixed-priority with starvation protection, or round-robin when configured.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MAX_WAIT, 8, cycles a waiting video request tolerates before it is forced to win (fixed-priority build only)
- Clk  in  1  clock; all logic on posedge
- Reset  in  1  synchronous, active-high
- CpuReq  in  1  CPU access request; held until CpuGnt seen
- CpuWe  in  1  1 = write, 0 = read; stable with CpuReq
- CpuAddr  in  ADDR_W  CPU address
- CpuWData  in  DATA_W  CPU write data
- CpuGnt  out  1  one-cycle pulse: CPU access issued
- CpuValid  out  1  one-cycle pulse: read data valid / write done
- CpuRData  out  DATA_W  read data; 0 when CpuValid = 0
- VidReq  in  1  video read request (read-only)
- VidAddr  in  ADDR_W  video address
- VidGnt  out  1  one-cycle pulse: video access issued
- VidValid  out  1  one-cycle pulse: video read data valid
- VidRData  out  DATA_W  read data; 0 when VidValid = 0
- RamAddr  out  ADDR_W  RAM address (registered)
- RamWData  out  DATA_W  RAM write data (registered)
- RamWe  out  1  RAM write enable (registered)
- RamRData  in  DATA_W  RAM read data; synchronous, 1-cycle latency

## Operation
- States:
  - IDLE: no access in flight.
  - ISSUE: Gnt of the winner = 1; RamAddr/RamWe/RamWData driven for the winner.
  - RESP: Valid of the owner = 1; RData = RamRData.
- Transitions:
  - IDLE → ISSUE if any Req is high, else stay in IDLE.
  - ISSUE → RESP always.
  - RESP → ISSUE if any Req is high, else → IDLE.
- Arbitration is evaluated only in IDLE and RESP, on the sampled Req lines.
- The requester granted in ISSUE must drop Req in RESP unless it wants a further access. A Req still high in RESP is a new request.
- Fixed priority (default): CPU wins ties.
  - VidWait counter increments each cycle VidReq = 1 and VidGnt = 0; it saturates at MAX_WAIT.
  - When VidWait = MAX_WAIT at an arbitration point, video wins. The counter clears on VidGnt.
- Video accesses always drive RamWe = 0 and RamWData = 0.
- Outside ISSUE, RamWe = 0 and RamAddr/RamWData hold their last value.
- No arithmetic beyond VidWait, which is clog2(MAX_WAIT+1) bits wide.
- Reset values: state IDLE; all Gnt/Valid/RData/RamWe/RamAddr/RamWData = 0; VidWait = 0; last-grant pointer = VID.
- Reset mid-access:
  - The FSM returns to IDLE and no Valid pulse is produced.
  - A write already sampled by the RAM completes. A write in ISSUE at the reset edge is not guaranteed.

## Timing
- Req high at the posedge ending cycle k (state IDLE) → Gnt during k+1 → Valid and RData during k+2.
- Back-to-back: the next Gnt is at k+3, so sustained throughput is one access per 2 cycles.
- Gnt and Valid are never both high for the same requester in one cycle. At most one Gnt and one Valid are asserted in any cycle.
- Req dropped before the Gnt cycle cancels the request; nothing is issued.

## Configuration
- MEM_ARB_RR_EN defined: round-robin.
  - On a tie, grant the requester not granted last; the pointer updates on each Gnt.
  - VidWait logic and MAX_WAIT are unused.
- MEM_ARB_RR_EN undefined: fixed CPU priority plus MAX_WAIT starvation guard, as above.

## Structure
- Shared package: FSM state encoding (IDLE/ISSUE/RESP), requester IDs REQ_CPU = 0 and REQ_VID = 1, default ADDR_W/DATA_W.
- One sub-module, mem_arb_pick: combinational winner select from CpuReq, VidReq, the last-grant pointer and the starvation flag.

## Test plan
- Reset held 2 cycles with CpuReq = 1 → all outputs 0 during reset; first CpuGnt in the second cycle after Reset falls.
- CPU write 0xBEEF to 0x0010, then read 0x0010:
  - Write: CpuGnt at k+1 with RamWe = 1 and RamAddr = 0x0010; CpuValid at k+2.
  - Read: CpuRData = 0xBEEF with CpuValid.
- Video alone reads 0x0100 preloaded with 0x1234 → VidGnt at k+1, VidValid with VidRData = 0x1234 at k+2; CpuGnt, CpuValid and CpuRData stay 0.
- Fixed build, CpuReq and VidReq held high continuously, MAX_WAIT = 8:
  - CPU wins until VidWait reaches 8; then one VidGnt occurs and VidWait clears.
  - The pattern repeats, and video is never starved.
- MEM_ARB_RR_EN build, both requesting continuously → grants alternate CPU, VID, CPU, VID, starting with CPU after reset.
- Reset asserted during the ISSUE cycle of a CPU read → no CpuValid; state IDLE; a new CpuReq is served with normal latency.
